// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if
//   Bundles the serial-detector control and status signals so that the
//   detector and whatever drives it share one connection.
//   master : sample enable, serial bit, pattern reload, counter clear (out);
//            match pulse and match count (in)
//   slave  : the detector side of the same signals
interface seq_detect_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               En;
  logic               In1;
  logic               Pat_Load;
  logic [PAT_LEN-1:0] Pat_In;
  logic               Cnt_Clr;
  logic               Out1;
  logic [CNT_W-1:0]   Match_Count;

  modport master (
    output En, In1, Pat_Load, Pat_In, Cnt_Clr,
    input  Out1, Match_Count
  );

  modport slave (
    input  En, In1, Pat_Load, Pat_In, Cnt_Clr,
    output Out1, Match_Count
  );
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector. Shifts in one bit per enabled clock, compares
//   the most recent PAT_LEN bits with a runtime-loadable pattern and emits a
//   registered one-cycle pulse per match. A saturating counter tallies
//   matches.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : En / In1 / Pat_Load / Pat_In / Cnt_Clr in, Out1 / Match_Count out
//   Parameters: PAT_LEN (2..32), PATTERN (reset pattern, MSB oldest),
//               OVERLAP (1 = overlapping matches), CNT_W (counter width)
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input logic                CLK,
  input logic                RST,
  seq_detect_param_if.slave  bus
);

  localparam int                FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q;
  // Only the newest PAT_LEN-1 bits are kept: the oldest bit of the window
  // falls out on the very shift that brings in the bit being compared.
  logic [PAT_LEN-2:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic               out_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [PAT_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               match;

  always_comb begin
    hist_n = {hist_q, bus.In1};
    fill_n = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
    // A reload takes priority over sampling, so it suppresses any match.
    match  = bus.En && !bus.Pat_Load && (fill_n == FULL) && (hist_n == pat_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (bus.Pat_Load) begin
        pat_q  <= bus.Pat_In;
        fill_q <= '0;
        out_q  <= 1'b0;
      end else if (bus.En) begin
        hist_q <= hist_n[PAT_LEN-2:0];
        out_q  <= match;
        fill_q <= (match && (OVERLAP == 1'b0)) ? '0 : fill_n;
      end else begin
        out_q  <= 1'b0;
      end

      if (bus.Cnt_Clr) begin
        cnt_q <= '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.Out1        = out_q;
  assign bus.Match_Count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic CLK;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Per-instance stimulus: 0 default, 1 non-overlap, 2 CNT_W=2,
  // 3 PAT_LEN=2 pattern 11, 4 PAT_LEN=32.
  logic        rst_s [5];
  logic        en_s  [5];
  logic        in_s  [5];
  logic        pl_s  [5];
  logic [31:0] pin_s [5];
  logic        clr_s [5];
  logic        o_s   [5];
  logic [31:0] c_s   [5];

  localparam int          PLEN [5] = '{4, 4, 4, 2, 32};
  localparam bit          OVL  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam int          CMAX [5] = '{255, 255, 3, 255, 255};
  localparam logic [31:0] RPAT [5] = '{32'hB, 32'hB, 32'hB, 32'h3, 32'hA5C3_96E1};

  seq_detect_param_if #(.PAT_LEN(4),  .CNT_W(8)) if0 ();
  seq_detect_param_if #(.PAT_LEN(4),  .CNT_W(8)) if1 ();
  seq_detect_param_if #(.PAT_LEN(4),  .CNT_W(2)) if2 ();
  seq_detect_param_if #(.PAT_LEN(2),  .CNT_W(8)) if3 ();
  seq_detect_param_if #(.PAT_LEN(32), .CNT_W(8)) if4 ();

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    dut0 (.CLK(CLK), .RST(rst_s[0]), .bus(if0));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    dut1 (.CLK(CLK), .RST(rst_s[1]), .bus(if1));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut2 (.CLK(CLK), .RST(rst_s[2]), .bus(if2));
  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8))
    dut3 (.CLK(CLK), .RST(rst_s[3]), .bus(if3));
  seq_detect_param #(.PAT_LEN(32), .PATTERN(32'hA5C3_96E1), .OVERLAP(1'b1), .CNT_W(8))
    dut4 (.CLK(CLK), .RST(rst_s[4]), .bus(if4));

  assign if0.En = en_s[0]; assign if0.In1 = in_s[0]; assign if0.Pat_Load = pl_s[0];
  assign if0.Pat_In = pin_s[0][3:0]; assign if0.Cnt_Clr = clr_s[0];
  assign if1.En = en_s[1]; assign if1.In1 = in_s[1]; assign if1.Pat_Load = pl_s[1];
  assign if1.Pat_In = pin_s[1][3:0]; assign if1.Cnt_Clr = clr_s[1];
  assign if2.En = en_s[2]; assign if2.In1 = in_s[2]; assign if2.Pat_Load = pl_s[2];
  assign if2.Pat_In = pin_s[2][3:0]; assign if2.Cnt_Clr = clr_s[2];
  assign if3.En = en_s[3]; assign if3.In1 = in_s[3]; assign if3.Pat_Load = pl_s[3];
  assign if3.Pat_In = pin_s[3][1:0]; assign if3.Cnt_Clr = clr_s[3];
  assign if4.En = en_s[4]; assign if4.In1 = in_s[4]; assign if4.Pat_Load = pl_s[4];
  assign if4.Pat_In = pin_s[4]; assign if4.Cnt_Clr = clr_s[4];

  assign o_s[0] = if0.Out1; assign c_s[0] = 32'(if0.Match_Count);
  assign o_s[1] = if1.Out1; assign c_s[1] = 32'(if1.Match_Count);
  assign o_s[2] = if2.Out1; assign c_s[2] = 32'(if2.Match_Count);
  assign o_s[3] = if3.Out1; assign c_s[3] = 32'(if3.Match_Count);
  assign o_s[4] = if4.Out1; assign c_s[4] = 32'(if4.Match_Count);

  int nchk = 0;
  int nfail = 0;
  bit chk_on = 1'b0;

  // Reference model: every consumed bit is appended to a log; m_base marks
  // where the usable history starts (moved by reset, reload, and a match
  // when overlapping is off). A match is the last PLEN logged bits, read
  // newest-first, equal to the pattern LSB-first.
  logic [31:0] m_pat  [5];
  int          m_wr   [5];
  int          m_base [5];
  bit          m_ring [5][64];
  bit          m_out  [5];
  int          m_cnt  [5];

  initial begin
    for (int k = 0; k < 5; k++) begin
      m_pat[k] = RPAT[k]; m_wr[k] = 0; m_base[k] = 0; m_out[k] = 0; m_cnt[k] = 0;
    end
  end

  always @(posedge CLK) begin
    for (int k = 0; k < 5; k++) begin
      bit hit;
      hit = 1'b0;
      if (rst_s[k]) begin
        m_pat[k] = RPAT[k]; m_base[k] = m_wr[k]; m_out[k] = 0; m_cnt[k] = 0;
      end else begin
        if (pl_s[k]) begin
          m_pat[k] = pin_s[k]; m_base[k] = m_wr[k]; m_out[k] = 0;
        end else if (en_s[k]) begin
          m_ring[k][m_wr[k] % 64] = in_s[k];
          m_wr[k]++;
          if (m_wr[k] - m_base[k] >= PLEN[k]) begin
            hit = 1'b1;
            for (int i = 0; i < PLEN[k]; i++)
              if (m_ring[k][(m_wr[k] - 1 - i) % 64] != m_pat[k][i]) hit = 1'b0;
          end
          m_out[k] = hit;
          if (hit && !OVL[k]) m_base[k] = m_wr[k];
        end else begin
          m_out[k] = 0;
        end
        if (clr_s[k]) m_cnt[k] = 0;
        else if (hit && m_cnt[k] < CMAX[k]) m_cnt[k]++;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      for (int k = 0; k < 5; k++) begin
        nchk++;
        if (o_s[k] !== m_out[k] || c_s[k] !== 32'(m_cnt[k])) begin
          nfail++;
          $display("FAIL model d%0d: got out=%0b cnt=%0d, want out=%0b cnt=%0d at %0t",
                   k, o_s[k], c_s[k], m_out[k], m_cnt[k], $time);
        end
      end
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    nchk++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic grp(input logic en, input logic b, input logic pl = 1'b0,
                     input logic [31:0] pin = 32'd0, input logic clr = 1'b0);
    for (int k = 0; k < 3; k++) begin
      en_s[k] = en; in_s[k] = b; pl_s[k] = pl; pin_s[k] = pin; clr_s[k] = clr;
    end
  endtask

  task automatic grp_rst();
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b1;
    grp(1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
  endtask

  // Stream n bits (MSB first) into instances 0..2 and check the pulses.
  task automatic run_seq(input string nm, input int n, input logic [31:0] s,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    for (int i = 0; i < n; i++) begin
      grp(1'b1, s[n-1-i]);
      tick();
      lit($sformatf("%s d0 bit%0d", nm, i + 1), int'(o_s[0]), int'(e0[n-1-i]));
      lit($sformatf("%s d1 bit%0d", nm, i + 1), int'(o_s[1]), int'(e1[n-1-i]));
      lit($sformatf("%s d2 bit%0d", nm, i + 1), int'(o_s[2]), int'(e2[n-1-i]));
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] rp;
    for (int k = 0; k < 5; k++) begin
      rst_s[k] = 1'b1; en_s[k] = 1'b1; in_s[k] = 1'b1;
      pl_s[k] = 1'b0; pin_s[k] = 32'd0; clr_s[k] = 1'b0;
    end
    // Reset held two cycles while the data inputs are active.
    tick();
    chk_on = 1'b1;
    tick();
    lit("reset out", int'(o_s[0]), 0);
    lit("reset cnt", int'(c_s[0]), 0);
    lit("reset pat", int'(dut0.pat_q), 4'b1011);
    for (int k = 0; k < 5; k++) begin rst_s[k] = 1'b0; en_s[k] = 1'b0; end

    // Overlap vs non-overlap.
    run_seq("ovl1", 7, 32'b1011011, 32'b0001001, 32'b0001000, 32'b0001001);
    lit("ovl1 cnt d0", int'(c_s[0]), 2);
    lit("ovl1 cnt d1", int'(c_s[1]), 1);
    lit("ovl1 model cnt d0", m_cnt[0], 2);
    grp_rst();
    run_seq("ovl2", 8, 32'b10111011, 32'b00010001, 32'b00010001, 32'b00010001);
    lit("ovl2 cnt d1", int'(c_s[1]), 2);

    // Gaps in En are transparent.
    grp_rst();
    grp(1'b1, 1'b1); tick();
    grp(1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      grp(1'b0, 1'b1); tick();
      lit("gap idle out", int'(o_s[0]), 0);
    end
    grp(1'b1, 1'b1); tick();
    lit("gap pre out", int'(o_s[0]), 0);
    grp(1'b1, 1'b1); tick();
    lit("gap match out", int'(o_s[0]), 1);

    // Reset mid-pattern discards the partial match.
    grp_rst();
    run_seq("prerst", 3, 32'b101, 32'b0, 32'b0, 32'b0);
    grp_rst();
    run_seq("postrst", 4, 32'b1011, 32'b0001, 32'b0001, 32'b0001);

    // Reload mid-stream; the En=1 bit at the load edge is not consumed.
    grp_rst();
    run_seq("preload", 3, 32'b101, 32'b0, 32'b0, 32'b0);
    grp(1'b1, 1'b1, 1'b1, 32'b0110); tick();
    lit("load out", int'(o_s[0]), 0);
    run_seq("newpat", 4, 32'b0110, 32'b0001, 32'b0001, 32'b0001);
    run_seq("oldpat", 4, 32'b1011, 32'b0, 32'b0, 32'b0);

    // Counter saturation and clear-wins-over-match.
    grp_rst();
    run_seq("sat", 16, 32'b1011011011011011,
            32'b0001001001001001, 32'b0001000001000001, 32'b0001001001001001);
    lit("sat cnt d2", int'(c_s[2]), 3);
    lit("sat cnt d0", int'(c_s[0]), 5);
    lit("sat cnt d1", int'(c_s[1]), 3);
    grp(1'b1, 1'b0); tick();
    grp(1'b1, 1'b1); tick();
    grp(1'b1, 1'b1, 1'b0, 32'd0, 1'b1); tick();
    lit("clr out d2", int'(o_s[2]), 1);
    lit("clr cnt d2", int'(c_s[2]), 0);
    lit("clr out d1", int'(o_s[1]), 0);
    grp(1'b0, 1'b0);

    // PAT_LEN=2, all-ones pattern with constant 1s.
    rst_s[3] = 1'b1; tick(); rst_s[3] = 1'b0;
    en_s[3] = 1'b1; in_s[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      lit($sformatf("len2 edge%0d", i + 1), int'(o_s[3]), (i >= 1) ? 1 : 0);
    end
    en_s[3] = 1'b0;

    // PAT_LEN=32: random pattern embedded three times in noise.
    rp = $urandom;
    pl_s[4] = 1'b1; pin_s[4] = rp; tick(); pl_s[4] = 1'b0;
    pulses = 0;
    en_s[4] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) begin
        in_s[4] = 1'($urandom); tick(); pulses += int'(o_s[4]);
      end
      for (int i = 31; i >= 0; i--) begin
        in_s[4] = rp[i]; tick(); pulses += int'(o_s[4]);
      end
    end
    lit("len32 pulses", pulses, 3);
    lit("len32 cnt", int'(c_s[4]), 3);

    // Randomized traffic on every instance.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 5; k++) begin
        rst_s[k] = ($urandom_range(199, 0) == 0);
        en_s[k]  = ($urandom_range(3, 0) != 0);
        in_s[k]  = 1'($urandom);
        pl_s[k]  = ($urandom_range(39, 0) == 0);
        pin_s[k] = $urandom;
        clr_s[k] = ($urandom_range(49, 0) == 0);
      end
      tick();
    end

    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
